// File: rtl/latch_arb_pkg.sv
// latch_arb_pkg
// Shared types and default sizing for the latch write arbiter.
//   state_t   : write sequencer states (IDLE, SETUP, STROBE, CLOSE)
//   NREQ_DEF  : default requester count
//   WIDTH_DEF : default latch bank width
//   HOLD_DEF  : default number of cycles the enable strobe stays high
package latch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    CLOSE  = 2'd3
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 3;
  localparam int HOLD_DEF  = 2;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selector: returns the first set bit of
// req_masked_i searching ptr_i, ptr_i+1, ... modulo NREQ.
//   req_masked_i : candidate requests (caller applies any masking)
//   ptr_i        : search start position
//   idx_o        : winning requester index (0 when nothing is set)
//   valid_o      : at least one candidate was set
module rr_picker
  import latch_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_masked_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [PW-1:0] pos;

  // Walk the offsets from the far end back to offset 0 so the last hit
  // written (smallest offset from ptr) is the one that sticks.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = PW'((int'(ptr_i) + i) % NREQ);
      if (req_masked_i[pos]) begin
        idx_o   = pos;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
// Round-robin arbiter that owns a level-sensitive latch bank. Each write is
// sequenced SETUP (data presented, enable low) -> STROBE (enable high for
// HOLD_CYCLES) -> CLOSE (enable low, data still held, Q compared), so the
// latch D input never moves while its enable is open.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   req        : per-requester level request, held until done
//   wdata      : requester i data at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, high for the whole transaction
//   done       : one-cycle completion pulse to the winner (during CLOSE)
//   lat_en     : latch bank enable
//   lat_d      : latch bank data
//   lat_q      : latch bank readback
//   busy       : sequencer is not IDLE
//   err        : sticky readback mismatch flag, cleared only by reset
//   err_id     : requester whose write last mismatched
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    lat_en,
  output logic [WIDTH-1:0]        lat_d,
  input  logic [WIDTH-1:0]        lat_q,
  output logic                    busy,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] err_id
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     wid_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              en_q;
  logic [WIDTH-1:0]  data_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              err_q;
  logic [PW-1:0]     err_id_q;

  logic [NREQ-1:0]   pick_req;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic              grant_now;
  logic [NREQ-1:0]   gnt_d;
  logic [PW-1:0]     ptr_d;
  logic [WIDTH-1:0]  data_d;

  // In CLOSE the current winner is masked so a requester that keeps req
  // high through its own done cannot immediately win again; it competes
  // from the next cycle on like any other new request.
  always_comb begin
    pick_req  = (state_q == CLOSE) ? (req & ~gnt_q) : req;
    grant_now = pick_valid && ((state_q == IDLE) || (state_q == CLOSE));
    gnt_d     = NREQ'(1) << pick_idx;
    ptr_d     = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
    data_d    = wdata[int'(pick_idx)*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req_masked_i (pick_req),
    .ptr_i        (ptr_q),
    .idx_o        (pick_idx),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wid_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
        end
        SETUP: begin
          state_q <= STROBE;
          en_q    <= 1'b1;
          cnt_q   <= CW'(HOLD_CYCLES - 1);
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q <= CLOSE;
            en_q    <= 1'b0;
            done_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CLOSE: begin
          // Enable has been closed for a full cycle, so Q is the value the
          // latch actually kept.
          if (lat_q != data_q) begin
            err_q    <= 1'b1;
            err_id_q <= wid_q;
          end
          if (!pick_valid) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Shared grant path for IDLE and CLOSE: lat_d only ever moves here,
      // i.e. on entry to SETUP while the enable is low.
      if (grant_now) begin
        state_q <= SETUP;
        gnt_q   <= gnt_d;
        wid_q   <= pick_idx;
        data_q  <= data_d;
        ptr_q   <= ptr_d;
        busy_q  <= 1'b1;
      end
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign lat_en = en_q;
  assign lat_d  = data_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign err_id = err_id_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter
// Directed bench: a per-cycle vector table (inputs applied, then the
// outputs produced by the previous edge compared) followed by hand-written
// sequences for pointer history, readback errors, late input changes and
// reset during the strobe. A behavioural latch models the bank.
module tb_latch_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        lat_en;
  logic [2:0]  lat_d;
  logic [2:0]  lat_q;
  logic        busy;
  logic        err;
  logic [1:0]  err_id;

  logic        force_bad;
  logic [2:0]  model_q;

  int checks;
  int errors;

  logic [3:0] exp_q[$];
  logic       mon_en;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        en;
    logic [2:0]  d;
    logic        busy;
    logic        err;
    logic [1:0]  eid;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  latch_write_arbiter #(
    .NREQ        (4),
    .WIDTH       (3),
    .HOLD_CYCLES (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .lat_en (lat_en),
    .lat_d  (lat_d),
    .lat_q  (lat_q),
    .busy   (busy),
    .err    (err),
    .err_id (err_id)
  );

  // latch bank model
  always_latch begin
    if (lat_en) model_q <= lat_d;
  end
  assign lat_q = force_bad ? 3'b000 : model_q;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // scoreboard: done pulses must appear in the queued order
  always @(negedge clk) begin
    if (mon_en && (done != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_done got=%0h exp=none", done);
      end else begin
        chk("mon_done", {28'd0, done}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    step();
    reset = 1'b0;
  endtask

  function automatic void add(input logic rst, input logic [3:0] rq, input logic [11:0] wd,
                              input logic [3:0] g, input logic [3:0] dn, input logic en,
                              input logic [2:0] d, input logic bsy, input logic er,
                              input logic [1:0] eid);
    vec_t v;
    v.rst = rst; v.req = rq; v.wdata = wd; v.gnt = g; v.done = dn;
    v.en = en; v.d = d; v.busy = bsy; v.err = er; v.eid = eid;
    vecs.push_back(v);
  endfunction

  initial begin
    int ord[5];
    logic [3:0] gv;
    logic [2:0] dv;

    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    force_bad = 1'b0;
    reset     = 1'b1;
    req       = 4'b0000;
    wdata     = 12'h000;

    // single write from requester 0, data 101
    add(1, 4'h0, 12'h005, 4'h0, 4'h0, 0, 3'd0, 0, 0, 2'd0);
    add(0, 4'h1, 12'h005, 4'h0, 4'h0, 0, 3'd0, 0, 0, 2'd0);
    add(0, 4'h1, 12'h005, 4'h1, 4'h0, 0, 3'd5, 1, 0, 2'd0);
    add(0, 4'h1, 12'h005, 4'h1, 4'h0, 1, 3'd5, 1, 0, 2'd0);
    add(0, 4'h1, 12'h005, 4'h1, 4'h0, 1, 3'd5, 1, 0, 2'd0);
    add(0, 4'h0, 12'h005, 4'h1, 4'h1, 0, 3'd5, 1, 0, 2'd0);
    add(0, 4'h0, 12'h005, 4'h0, 4'h0, 0, 3'd5, 0, 0, 2'd0);

    // all four requesting, data 001/010/011/100: order 0,1,2,3,0 with no gaps
    add(1, 4'h0, 12'h8D1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 2'd0);
    add(0, 4'hF, 12'h8D1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 2'd0);
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      gv = 4'(1 << ord[k]);
      dv = 3'(ord[k] + 1);
      add(0, 4'hF, 12'h8D1, gv, 4'h0, 0, dv, 1, 0, 2'd0);
      add(0, 4'hF, 12'h8D1, gv, 4'h0, 1, dv, 1, 0, 2'd0);
      add(0, 4'hF, 12'h8D1, gv, 4'h0, 1, dv, 1, 0, 2'd0);
      add(0, (k == 4) ? 4'h0 : 4'hF, 12'h8D1, gv, gv, 0, dv, 1, 0, 2'd0);
    end
    add(0, 4'h0, 12'h8D1, 4'h0, 4'h0, 0, 3'd1, 0, 0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      #1;
      chk($sformatf("row%0d gnt", i),    {28'd0, gnt},    {28'd0, vecs[i].gnt});
      chk($sformatf("row%0d done", i),   {28'd0, done},   {28'd0, vecs[i].done});
      chk($sformatf("row%0d lat_en", i), {31'd0, lat_en}, {31'd0, vecs[i].en});
      chk($sformatf("row%0d lat_d", i),  {29'd0, lat_d},  {29'd0, vecs[i].d});
      chk($sformatf("row%0d busy", i),   {31'd0, busy},   {31'd0, vecs[i].busy});
      chk($sformatf("row%0d err", i),    {31'd0, err},    {31'd0, vecs[i].err});
      chk($sformatf("row%0d err_id", i), {30'd0, err_id}, {30'd0, vecs[i].eid});
      @(posedge clk);
      #1;
    end

    // pointer left at 2 by a grant to 1; then 0 and 1 request together
    do_reset();
    req = 4'b0010; wdata = 12'h010;
    step();
    chk("ptr_pre gnt", {28'd0, gnt}, 32'h2);
    step(); step(); step();
    req = 4'b0000;
    step();
    mon_en = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    req = 4'b0011; wdata = 12'h00A;
    step();
    chk("ptr_wrap gnt0", {28'd0, gnt}, 32'h1);
    chk("ptr_wrap d0", {29'd0, lat_d}, 32'h2);
    step(); step(); step();
    req = 4'b0010;
    step();
    chk("ptr_wrap gnt1", {28'd0, gnt}, 32'h2);
    chk("ptr_wrap d1", {29'd0, lat_d}, 32'h1);
    chk("ptr_wrap busy", {31'd0, busy}, 32'h1);
    step(); step(); step();
    req = 4'b0000;
    step();
    chk("ptr_wrap idle", {31'd0, busy}, 32'h0);
    mon_en = 1'b0;
    chk("sb_empty", exp_q.size(), 32'd0);

    // readback mismatch from requester 2, then a good write
    do_reset();
    force_bad = 1'b1;
    req = 4'b0100; wdata = 12'h1C0;
    step();
    chk("bad gnt", {28'd0, gnt}, 32'h4);
    chk("bad lat_d", {29'd0, lat_d}, 32'h7);
    step(); step(); step();
    chk("bad err_in_close", {31'd0, err}, 32'h0);
    req = 4'b0000;
    step();
    chk("bad err", {31'd0, err}, 32'h1);
    chk("bad err_id", {30'd0, err_id}, 32'h2);
    force_bad = 1'b0;
    req = 4'b0001; wdata = 12'h1C2;
    step();
    chk("good gnt", {28'd0, gnt}, 32'h1);
    step(); step(); step();
    chk("good done", {28'd0, done}, 32'h1);
    req = 4'b0000;
    step();
    chk("sticky err", {31'd0, err}, 32'h1);
    chk("sticky err_id", {30'd0, err_id}, 32'h2);

    // data and req change during STROBE are ignored
    do_reset();
    req = 4'b0001; wdata = 12'h006;
    step();
    step();
    chk("late strobe1 en", {31'd0, lat_en}, 32'h1);
    wdata = 12'h001; req = 4'b0000;
    step();
    chk("late strobe2 d", {29'd0, lat_d}, 32'h6);
    step();
    chk("late done", {28'd0, done}, 32'h1);
    chk("late close d", {29'd0, lat_d}, 32'h6);
    step();
    chk("late idle gnt", {28'd0, gnt}, 32'h0);
    chk("late idle d", {29'd0, lat_d}, 32'h6);

    // reset in the second STROBE cycle; afterwards pointer is back at 0
    do_reset();
    req = 4'b0001; wdata = 12'h003;
    step(); step(); step();
    chk("rst pre en", {31'd0, lat_en}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst en", {31'd0, lat_en}, 32'h0);
    chk("rst gnt", {28'd0, gnt}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    step();
    reset = 1'b0;
    req = 4'b0011; wdata = 12'h00B;
    step();
    chk("rst restart gnt", {28'd0, gnt}, 32'h1);
    chk("rst restart d", {29'd0, lat_d}, 32'h3);
    req = 4'b0000;
    step(); step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
